// File: rtl/full_adder.sv
// Registered ripple-carry full-adder slice.
// WIDTH one-bit cells are chained through a carry vector; the combinational
// result is exposed directly and also captured into a one-cycle output
// register with valid tracking. WIDTH=1 is the plain single-bit full adder.

// One-bit full-adder cell: the leaf of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term is shared between the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s_c,
  output logic             co_c,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid
);
  // c[i] is the carry into bit i; c[WIDTH] is the carry-out of the slice.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  // One cell per bit; cell i consumes c[i] and produces c[i+1].
  full_adder_cell u_cell [WIDTH-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[WIDTH-1:0]),
    .s  (s_c),
    .co (c[WIDTH:1])
  );

  assign co_c = c[WIDTH];

  // Result register: capture on valid, otherwise hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s  <= '0;
      co <= 1'b0;
    end else if (in_valid) begin
      s  <= s_c;
      co <= co_c;
    end
  end

  // Valid tracks in_valid one cycle later; reset wins over a same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end
endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: WIDTH=1 truth table, reset and hold on one
// instance; WIDTH=4 overflow, mid-stream reset and back-to-back throughput on
// a second instance.
module tb_full_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       rst1, v1, a1, b1, ci1;
  logic       sc1, coc1, s1, co1, ov1;
  // WIDTH=4 instance
  logic       rst4, v4, ci4;
  logic [3:0] a4, b4, sc4, s4;
  logic       coc4, co4, ov4;

  int checks = 0;
  int fails  = 0;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .a(a1), .b(b1), .ci(ci1),
    .s_c(sc1), .co_c(coc1), .s(s1), .co(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .a(a4), .b(b4), .ci(ci4),
    .s_c(sc4), .co_c(coc4), .s(s4), .co(co4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth-table vectors in {ci,b,a} order with hand-computed {co,s}.
  logic [2:0] tt_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic [1:0] tt_out [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [4:0] exp5;
    rst1 = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    rst4 = 1'b1; v4 = 1'b0; a4 = '0;   b4 = '0;   ci4 = 1'b0;

    // Reset held two cycles with valid operands present: outputs stay clear.
    tick();
    chk("rst1_e1_s",  32'(s1),  0);
    chk("rst1_e1_co", 32'(co1), 0);
    chk("rst1_e1_ov", 32'(ov1), 0);
    chk("rst4_s",     32'(s4),  0);
    chk("rst4_ov",    32'(ov4), 0);
    tick();
    chk("rst1_e2_s",  32'(s1),  0);
    chk("rst1_e2_ov", 32'(ov1), 0);
    rst1 = 1'b0; rst4 = 1'b0;
    tick();
    chk("rst1_rel_s",  32'(s1),  1);
    chk("rst1_rel_co", 32'(co1), 1);
    chk("rst1_rel_ov", 32'(ov1), 1);

    // Exhaustive WIDTH=1 truth table, combinational and registered.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] vin;
      vin = tt_in[i];
      ci1 = vin[2]; b1 = vin[1]; a1 = vin[0]; v1 = 1'b1;
      #1;
      chk($sformatf("tt%0d_comb", i), 32'({coc1, sc1}), 32'(tt_out[i]));
      tick();
      chk($sformatf("tt%0d_reg", i), 32'({co1, s1}), 32'(tt_out[i]));
      chk($sformatf("tt%0d_ov", i),  32'(ov1), 1);
    end

    // Hold: capture 1+0+0, then drop valid while operands keep changing.
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; v1 = 1'b1;
    tick();
    chk("hold_cap_s",  32'(s1),  1);
    chk("hold_cap_co", 32'(co1), 0);
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = 1'b1; b1 = 1'b1; ci1 = i[0];
      #1;
      chk($sformatf("hold%0d_comb", i), 32'({coc1, sc1}), (i[0] ? 3 : 2));
      tick();
      chk($sformatf("hold%0d_s", i),  32'(s1),  1);
      chk($sformatf("hold%0d_co", i), 32'(co1), 0);
      chk($sformatf("hold%0d_ov", i), 32'(ov1), 0);
    end

    // WIDTH=4 overflow and carry-propagation corners.
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0;
    #1;
    chk("ovf1_comb", 32'({coc4, sc4}), 32'h10);
    tick();
    chk("ovf1_reg",  32'({co4, s4}), 32'h10);
    a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    #1;
    chk("ovf2_comb", 32'({coc4, sc4}), 32'h1F);
    tick();
    chk("ovf2_reg",  32'({co4, s4}), 32'h1F);
    a4 = 4'h5; b4 = 4'hA; ci4 = 1'b0;
    #1;
    chk("alt_comb", 32'({coc4, sc4}), 32'h0F);
    tick();
    chk("alt_reg",  32'({co4, s4}), 32'h0F);
    chk("alt_ov",   32'(ov4), 1);

    // Reset mid-stream: the operand presented with rst is discarded.
    b4 = 4'h1; ci4 = 1'b0; a4 = 4'h3;
    tick();
    chk("mid_a3_s",  32'(s4),  4);
    chk("mid_a3_ov", 32'(ov4), 1);
    a4 = 4'h4; rst4 = 1'b1;
    tick();
    chk("mid_rst_s",  32'(s4),  0);
    chk("mid_rst_co", 32'(co4), 0);
    chk("mid_rst_ov", 32'(ov4), 0);
    a4 = 4'h5; rst4 = 1'b0;
    tick();
    chk("mid_a5_s",  32'(s4),  6);
    chk("mid_a5_ov", 32'(ov4), 1);

    // Back-to-back random operands at full throughput.
    for (int i = 0; i < 16; i++) begin
      a4  = 4'($urandom_range(15));
      b4  = 4'($urandom_range(15));
      ci4 = 1'($urandom_range(1));
      exp5 = {1'b0, a4} + {1'b0, b4} + {4'b0, ci4};
      tick();
      chk($sformatf("b2b%0d_sum", i), 32'({co4, s4}), 32'(exp5));
      chk($sformatf("b2b%0d_ov", i),  32'(ov4), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry full-adder slice built from WIDTH one-bit full-adder cells. The cell is sum = a^b^ci, carry = ab | ci(a^b).
- Default WIDTH=1 is the canonical single-bit full adder.
- Used as the leaf arithmetic element of the carry-select adder datapath.
- Provides a combinational result and a one-cycle registered result with valid tracking.

Parameters:
- WIDTH, 1, operand width in bits (>=1); number of chained one-bit cells.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle; result captured at next clk edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in to bit 0
- s_c  output  WIDTH  combinational sum, a+b+ci low WIDTH bits
- co_c  output  1  combinational carry-out, bit WIDTH of a+b+ci
- s  output  WIDTH  registered sum
- co  output  1  registered carry-out
- out_valid  output  1  registered result valid

Behaviour:
- Arithmetic: {co_c, s_c} = a + b + ci, evaluated as an unsigned (WIDTH+1)-bit value. No truncation other than the natural WIDTH+1 result.
- Structure is a ripple chain:
  - c[0] = ci
  - s_c[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
  - co_c = c[WIDTH]
- Combinational outputs respond to input changes within the same cycle; no clock dependence.
- Registered path, 1-cycle latency. At a rising clk edge:
  - if rst=1: s<=0, co<=0, out_valid<=0.
  - else if in_valid=1: s<=s_c, co<=co_c, out_valid<=1.
  - else: s and co hold their previous values; out_valid<=0.
- Reset values: s=0, co=0, out_valid=0. Reset is synchronous; an asserted rst between edges has no effect until the next edge.
- rst dominates in_valid on the same edge; the operand presented with rst is discarded.
- Back-to-back in_valid: one result per cycle, full throughput, no stall or backpressure.
- Overflow: maximal operands (all ones, ci=1) give s = all ones, co=1. No saturation, no error flag.
- Every output is driven at all times; no latches; outputs before the first reset are undefined.

Test Plan:
- WIDTH=1 exhaustive truth table, a/b/ci stepped through 000, 010, 100, 110, 001, 011, 101, 111 (ci,b,a order as listed), 10 ns per step:
  - required {co_c,s_c}: 00, 01, 01, 10, 01, 10, 10, 11.
  - with in_valid=1, registered {co,s} matches each value one clk later.
- Reset: rst=1 for 2 cycles with in_valid=1, a=1, b=1, ci=1 -> s=0, co=0, out_valid=0 after the edge. The first edge after rst drops gives s=1, co=1, out_valid=1.
- Hold: capture a=1, b=0, ci=0 (s=1, co=0), then drop in_valid for 3 cycles with changing operands -> s=1 and co=0 held; out_valid=0 from the next edge.
- WIDTH=4 overflow: a=4'hF, b=4'h1, ci=0 -> s=4'h0, co=1. Also a=4'hF, b=4'hF, ci=1 -> s=4'hF, co=1. Also a=4'h5, b=4'hA, ci=0 -> s=4'hF, co=0.
- Reset mid-stream: in_valid=1 streaming a=3, 4, 5 (WIDTH=4, b=1, ci=0), rst asserted on the edge that would capture a=4 -> outputs 0, out_valid=0. The next edge captures a=5 -> s=6, out_valid=1.
- Back-to-back throughput: 16 consecutive random operand sets with in_valid=1 -> each registered result equals the reference a+b+ci exactly one cycle later; out_valid stays 1.
